// File: rtl/cic_comp_fir_pkg.sv
// Shared types for the CIC droop-compensation decimating FIR.
// Holds the MAC sequencer state encoding used by the top level.
// No logic; imported by cic_comp_fir.
package cic_comp_fir_pkg;

   // IDLE waits for a run start, MAC walks the taps, ROUND registers the result.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_ROUND = 2'd2
   } state_t;

endpackage

// File: rtl/cic_comp_mac.sv
// Time-shared multiply-accumulate with round-half-up and output saturation.
// Latency: acc_out updates one clock after en; sat_out is combinational from acc.
// No backpressure: accumulates every cycle en is high, clr wins over en.
// Ports: CLK/RSTb clock and async active-low reset; clr zeroes the accumulator;
//        en adds sample*coef; sample/coef signed operands; acc_out raw accumulator;
//        sat_out = saturate((acc + 2^(COEF_BITS-2)) >>> (COEF_BITS-1)).
module cic_comp_mac #(
   parameter int BITS      = 16,
   parameter int COEF_BITS = 18,
   parameter int ACC_WIDTH = 48
) (
   input  logic                        CLK,
   input  logic                        RSTb,
   input  logic                        clr,
   input  logic                        en,
   input  logic signed [BITS-1:0]      sample,
   input  logic signed [COEF_BITS-1:0] coef,
   output logic signed [ACC_WIDTH-1:0] acc_out,
   output logic signed [BITS-1:0]      sat_out
);

   localparam int PROD_W = BITS + COEF_BITS;
   localparam int SHIFT  = COEF_BITS - 1;

   // Half an output LSB: coefficients are Q1.(COEF_BITS-1).
   localparam logic signed [ACC_WIDTH-1:0] RND_K =
      {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (COEF_BITS - 2);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

   logic signed [PROD_W-1:0]    w_sample_x;
   logic signed [PROD_W-1:0]    w_coef_x;
   logic signed [PROD_W-1:0]    w_prod;
   logic signed [ACC_WIDTH-1:0] w_prod_x;
   logic signed [ACC_WIDTH-1:0] w_rnd;
   logic signed [ACC_WIDTH-1:0] w_shift;
   logic signed [ACC_WIDTH-1:0] r_acc;

   // Sign-extend both operands so the product is exact at full width.
   assign w_sample_x = {{COEF_BITS{sample[BITS-1]}}, sample};
   assign w_coef_x   = {{BITS{coef[COEF_BITS-1]}}, coef};
   assign w_prod     = w_sample_x * w_coef_x;
   assign w_prod_x   = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_acc <= '0;
      end else if (clr) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= r_acc + w_prod_x;
      end
   end

   // Ties go toward +inf: add half an LSB, then floor via arithmetic shift.
   assign w_rnd   = r_acc + RND_K;
   assign w_shift = w_rnd >>> SHIFT;

   always_comb begin
      sat_out = w_shift[BITS-1:0];
      if (w_shift > SAT_MAX) begin
         sat_out = SAT_MAX[BITS-1:0];
      end else if (w_shift < SAT_MIN) begin
         sat_out = SAT_MIN[BITS-1:0];
      end
   end

   assign acc_out = r_acc;

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensating FIR, decimate by DECIM, one shared MAC over TAPS cycles.
// Latency: run-starting in_tick in cycle 0 -> out_tick/x_out in cycle TAPS+2.
// No backpressure: samples are always accepted; a run start while busy is dropped
// and flagged on the sticky overrun output (cleared only by RSTb).
// Ports: CLK, RSTb (async active-low); x_in/in_tick sample strobe from the CIC;
//        x_out/out_tick filtered sample and its one-cycle strobe; busy while a
//        MAC run is active; overrun sticky flag.
// Coefficients come in as COEF_INIT, c[k] at bits [k*COEF_BITS +: COEF_BITS],
// c[0] multiplying the newest sample.
module cic_comp_fir
   import cic_comp_fir_pkg::*;
#(
   parameter int BITS      = 16,
   parameter int TAPS      = 32,
   parameter int COEF_BITS = 18,
   parameter int DECIM     = 2,
   parameter int ACC_WIDTH = 48,
   parameter logic [TAPS*COEF_BITS-1:0] COEF_INIT = '0
) (
   input  logic                   CLK,
   input  logic                   RSTb,
   input  logic signed [BITS-1:0] x_in,
   input  logic                   in_tick,
   output logic signed [BITS-1:0] x_out,
   output logic                   out_tick,
   output logic                   busy,
   output logic                   overrun
);

   localparam int AW = $clog2(TAPS);
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic signed [BITS-1:0] r_buf [TAPS];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_base;
   logic [AW-1:0]          r_idx;
   logic [PW-1:0]          r_ph;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic signed [BITS-1:0] r_x_out;
   logic                   r_out_tick;
   logic                   r_overrun;

   logic                        w_run_req;
   logic                        w_clr;
   logic                        w_en;
   logic                        w_out_ld;
   logic [AW-1:0]               w_rd_addr;
   logic signed [BITS-1:0]      w_sample;
   logic signed [COEF_BITS-1:0] w_coef;
   logic signed [BITS-1:0]      w_sat;
   logic signed [ACC_WIDTH-1:0] w_unused_acc;

   assign w_run_req = in_tick && (r_ph == PW'(DECIM - 1));

   // Sample buffer and write pointer; natural wrap since TAPS is a power of two.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         for (int i = 0; i < TAPS; i++) begin
            r_buf[i] <= '0;
         end
         r_wr_ptr <= '0;
      end else if (in_tick) begin
         r_buf[r_wr_ptr] <= x_in;
         r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
   end

   // Phase advances on every tick, including ticks that arrive mid-run.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_ph <= '0;
      end else if (in_tick) begin
         r_ph <= w_run_req ? '0 : r_ph + PW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_overrun <= 1'b0;
      end else if (in_tick && (r_state != ST_IDLE)) begin
         r_overrun <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_en        = 1'b0;
      w_out_ld    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_run_req) begin
               w_state_nxt = ST_MAC;
               w_clr       = 1'b1;
            end
         end
         ST_MAC: begin
            w_en = 1'b1;
            if (r_idx == AW'(TAPS - 1)) begin
               w_state_nxt = ST_ROUND;
            end
         end
         ST_ROUND: begin
            w_out_ld    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // base marks the sample written by the run-starting tick (pre-increment pointer).
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_base <= '0;
         r_idx  <= '0;
      end else begin
         if (w_clr) begin
            r_base <= r_wr_ptr;
            r_idx  <= '0;
         end else if (w_en) begin
            r_idx <= r_idx + AW'(1);
         end
      end
   end

   // Walk backwards in time from the newest sample; mod TAPS by pointer width.
   assign w_rd_addr = r_base - r_idx;
   assign w_sample  = r_buf[w_rd_addr];
   assign w_coef    = $signed(COEF_INIT[int'(r_idx)*COEF_BITS +: COEF_BITS]);

   cic_comp_mac #(
      .BITS      (BITS),
      .COEF_BITS (COEF_BITS),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_mac (
      .CLK     (CLK),
      .RSTb    (RSTb),
      .clr     (w_clr),
      .en      (w_en),
      .sample  (w_sample),
      .coef    (w_coef),
      .acc_out (w_unused_acc),
      .sat_out (w_sat)
   );

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_x_out    <= '0;
         r_out_tick <= 1'b0;
      end else begin
         r_out_tick <= w_out_ld;
         if (w_out_ld) begin
            r_x_out <= w_sat;
         end
      end
   end

   assign x_out    = r_x_out;
   assign out_tick = r_out_tick;
   assign busy     = (r_state != ST_IDLE);
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: two instances (TAPS=8).
// Instance A: DECIM=2, c[k]=8k+8. Instance B: DECIM=1, c0=4, c1=-1, c6=c7=131071.
// Table vectors for impulse/rounding/saturation, hand sequences for the rest.
module tb_cic_comp_fir;

   logic CLK = 1'b0;
   logic RSTb = 1'b0;

   logic signed [15:0] xa = '0, xb = '0, ya, yb;
   logic tick_a = 1'b0, tick_b = 1'b0;
   logic oa, ob, ba, bb, ova, ovb;

   localparam logic [8*18-1:0] COEF_A =
      {18'd64, 18'd56, 18'd48, 18'd40, 18'd32, 18'd24, 18'd16, 18'd8};
   localparam logic [8*18-1:0] COEF_B =
      {18'h1FFFF, 18'h1FFFF, 18'd0, 18'd0, 18'd0, 18'd0, 18'h3FFFF, 18'd4};

   cic_comp_fir #(.BITS(16), .TAPS(8), .COEF_BITS(18), .DECIM(2), .ACC_WIDTH(48),
                  .COEF_INIT(COEF_A)) u_dut_a (
      .CLK(CLK), .RSTb(RSTb), .x_in(xa), .in_tick(tick_a),
      .x_out(ya), .out_tick(oa), .busy(ba), .overrun(ova));

   cic_comp_fir #(.BITS(16), .TAPS(8), .COEF_BITS(18), .DECIM(1), .ACC_WIDTH(48),
                  .COEF_INIT(COEF_B)) u_dut_b (
      .CLK(CLK), .RSTb(RSTb), .x_in(xb), .in_tick(tick_b),
      .x_out(yb), .out_tick(ob), .busy(bb), .overrun(ovb));

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int ot_a = 0;

   always @(negedge CLK) if (oa) ot_a++;

   typedef struct {
      bit inst;
      int x;
      bit run;
      bit chk;
      int exp;
   } vec_t;

   vec_t tbl[$];
   int   h[24];
   int   lat;
   logic signed [15:0] val;
   bit   got;
   int   c0;

   task automatic add(input bit inst, input int x, input bit run, input bit chk, input int exp);
      vec_t v;
      v.inst = inst; v.x = x; v.run = run; v.chk = chk; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic send(input bit inst, input int x);
      if (inst) begin
         xb = 16'(x); tick_b = 1'b1;
      end else begin
         xa = 16'(x); tick_a = 1'b1;
      end
      @(posedge CLK); #1;
      tick_a = 1'b0;
      tick_b = 1'b0;
   endtask

   task automatic wait_out(input bit inst, input int max);
      got = 1'b0; lat = 0; val = '0;
      for (int n = 1; n <= max; n++) begin
         @(posedge CLK); #1;
         if ((inst ? ob : oa) == 1'b1) begin
            got = 1'b1; lat = n; val = inst ? yb : ya;
            break;
         end
      end
   endtask

   task automatic do_reset();
      RSTb = 1'b0;
      idle(2);
      RSTb = 1'b1;
   endtask

   // Reference FIR for instance A over history h[0..k].
   function automatic int model(input int k);
      longint acc = 0;
      for (int j = 0; j < 8; j++) begin
         if (k - j >= 0) acc += longint'(h[k-j]) * longint'(8*j + 8);
      end
      acc = (acc + 64'sd65536) >>> 17;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   initial begin
      // Impulse on A: outputs are c[0],c[2],c[4],c[6] scaled = 1,3,5,7 then 0.
      add(0, 0, 0, 0, 0);
      add(0, 16384, 1, 1, 1);
      add(0, 0, 0, 0, 0); add(0, 0, 1, 1, 3);
      add(0, 0, 0, 0, 0); add(0, 0, 1, 1, 5);
      add(0, 0, 0, 0, 0); add(0, 0, 1, 1, 7);
      add(0, 0, 0, 0, 0); add(0, 0, 1, 1, 0);
      // Rounding on B: acc = 65536 -> 1, -16380 -> 0, 65535 -> 0, -81920 -> -1, 16384 -> 0.
      add(1, 16384, 1, 1, 1);
      add(1, 1, 1, 1, 0);
      add(1, 16384, 1, 1, 0);
      add(1, -16384, 1, 1, -1);
      add(1, 0, 1, 1, 0);
      // Large positive on B, then full-scale saturation both ways.
      add(1, 32767, 1, 1, 1);
      add(1, 32767, 1, 1, 16385);
      for (int i = 0; i < 5; i++) add(1, 32767, 1, 0, 0);
      add(1, 32767, 1, 1, 32767);
      for (int i = 0; i < 7; i++) add(1, -32768, 1, 0, 0);
      add(1, -32768, 1, 1, -32768);

      // Reset state.
      idle(3);
      check("rst_xout_a", int'(ya), 0);
      check("rst_otick_a", int'(oa), 0);
      check("rst_busy_a", int'(ba), 0);
      check("rst_ovr_a", int'(ova), 0);
      check("rst_xout_b", int'(yb), 0);
      check("rst_otick_b", int'(ob), 0);
      check("rst_busy_b", int'(bb), 0);
      check("rst_ovr_b", int'(ovb), 0);
      RSTb = 1'b1;
      idle(2);

      foreach (tbl[i]) begin
         send(tbl[i].inst, tbl[i].x);
         if (tbl[i].run) begin
            wait_out(tbl[i].inst, 20);
            check($sformatf("vec%0d_out_seen", i), int'(got), 1);
            if (tbl[i].chk) begin
               check($sformatf("vec%0d_x_out", i), int'(val), tbl[i].exp);
               check($sformatf("vec%0d_latency", i), lat + 1, 10);
            end
         end
         idle(2);
      end

      // Overrun: ticks every 4 cycles.
      do_reset();
      c0 = ot_a;
      send(0, 100); idle(3);
      send(0, 200);
      check("ovr_busy_run", int'(ba), 1);
      check("ovr_before", int'(ova), 0);
      idle(3);
      send(0, 300);
      check("ovr_set", int'(ova), 1);
      idle(3);
      send(0, 400);
      check("ovr_busy_drop", int'(ba), 1);
      idle(30);
      check("ovr_one_out_tick", ot_a - c0, 1);
      check("ovr_sticky", int'(ova), 1);
      check("ovr_idle_after", int'(ba), 0);

      // Nonzero output first, then reset in cycle 5 of a MAC run.
      send(0, 16384); idle(2);
      send(0, 16384);
      wait_out(0, 20);
      check("pre_rst_out_seen", int'(got), 1);
      check("pre_rst_x_out", int'(val), 3);
      check("ovr_still_set", int'(ova), 1);
      idle(2);
      send(0, 0); idle(2);
      send(0, 0);
      idle(4);
      check("midrun_busy", int'(ba), 1);
      RSTb = 1'b0;
      #1;
      check("midrun_rst_xout", int'(ya), 0);
      check("midrun_rst_otick", int'(oa), 0);
      check("midrun_rst_busy", int'(ba), 0);
      check("midrun_rst_ovr", int'(ova), 0);
      idle(2);
      RSTb = 1'b1;
      c0 = ot_a;
      idle(15);
      check("midrun_no_out", ot_a - c0, 0);
      send(0, 16384);
      idle(12);
      check("post_rst_one_tick_no_out", ot_a - c0, 0);
      send(0, 16384);
      wait_out(0, 20);
      check("post_rst_out_seen", int'(got), 1);
      check("post_rst_latency", lat + 1, 10);
      check("post_rst_x_out", int'(val), 3);
      idle(2);

      // Wrap-around: 3*TAPS ramp samples against the reference FIR.
      do_reset();
      for (int k = 0; k < 24; k++) begin
         h[k] = (k + 1) * 1000;
         send(0, h[k]);
         if (k % 2 == 1) begin
            wait_out(0, 20);
            check($sformatf("wrap%0d_out_seen", k), int'(got), 1);
            check($sformatf("wrap%0d_x_out", k), int'(val), model(k));
         end
         idle(2);
      end
      check("wrap_no_overrun", int'(ova), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
